// File: rtl/imem_load_sink_pkg.sv
// Shared constants and state encoding for the boot-loaded instruction memory.
package imem_load_sink_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_load_sink_if.sv
// Injector load stream, fetch port and load status of the instruction memory.
interface imem_load_sink_if #(
  parameter int AW = 10
);
  logic          load_valid;
  logic [31:0]   load_addr;
  logic [31:0]   load_instr;
  logic          load_done;
  logic          loaded;
  logic [AW:0]   load_count;
  logic          load_overflow;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_err;

  modport master (
    output load_valid, load_addr, load_instr, load_done, fetch_req, fetch_pc,
    input  loaded, load_count, load_overflow, fetch_ready, fetch_valid,
           fetch_instr, fetch_err
  );

  modport slave (
    input  load_valid, load_addr, load_instr, load_done, fetch_req, fetch_pc,
    output loaded, load_count, load_overflow, fetch_ready, fetch_valid,
           fetch_instr, fetch_err
  );
endinterface

// File: rtl/imem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so
// it maps onto block RAM.
module imem_sdp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_load_sink.sv
// Instruction memory filled by the boot injector, then serving core fetches
// with one-cycle latency and an error flag for illegal addresses.
//   state | meaning
//   LOAD  | accepting injector writes, fetch held off
//   RUN   | load finished, serving fetches, writes ignored
module imem_load_sink
  import imem_load_sink_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  imem_load_sink_if.slave bus
);
  state_e        state_q, state_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          load_overflow_q, load_overflow_d;
  logic          fetch_valid_q, fetch_err_q, resp_seen_q;
  logic          load_in_range, ram_we, fetch_accept, fetch_bad;
  logic [AW:0]   load_next;
  logic [AW-1:0] fetch_idx;
  logic [31:0]   ram_rdata;

  always_comb begin
    state_d         = state_q;
    load_count_d    = load_count_q;
    load_overflow_d = load_overflow_q;
    ram_we          = 1'b0;
    load_in_range   = bus.load_addr < 32'(DEPTH);
    load_next       = {1'b0, bus.load_addr[AW-1:0]} + {{AW{1'b0}}, 1'b1};
    case (state_q)
      LOAD: begin
        if (bus.load_valid) begin
          if (load_in_range) begin
            ram_we = 1'b1;
            if (load_next > load_count_q) load_count_d = load_next;
          end else begin
            load_overflow_d = 1'b1;
          end
        end
        if (bus.load_done) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // Range checks run on the full 32-bit pc so high aliases are flagged.
  assign fetch_idx    = bus.fetch_pc[AW+1:2];
  assign fetch_accept = bus.fetch_req && bus.fetch_ready;
  assign fetch_bad    = (bus.fetch_pc[1:0] != 2'b00)
                     || (bus.fetch_pc >= 32'(4 * DEPTH))
                     || ({1'b0, fetch_idx} >= load_count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOAD;
      load_count_q    <= '0;
      load_overflow_q <= 1'b0;
      fetch_valid_q   <= 1'b0;
      fetch_err_q     <= 1'b0;
      resp_seen_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_count_q    <= load_count_d;
      load_overflow_q <= load_overflow_d;
      fetch_valid_q   <= fetch_accept;
      if (fetch_accept) begin
        fetch_err_q <= fetch_bad;
        resp_seen_q <= 1'b1;
      end
    end
  end

  imem_sdp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (bus.load_addr[AW-1:0]),
    .wdata_i (bus.load_instr),
    .re_i    (fetch_accept),
    .raddr_i (fetch_idx),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is not reset, so mask it until the first response.
  assign bus.fetch_instr   = !resp_seen_q ? 32'h0 :
                             (fetch_err_q ? NOP_INSTR : ram_rdata);
  assign bus.fetch_err     = fetch_err_q;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_ready   = (state_q == RUN);
  assign bus.loaded        = (state_q == RUN);
  assign bus.load_count    = load_count_q;
  assign bus.load_overflow = load_overflow_q;
endmodule

// File: doc/imem_load_sink.md
# imem_load_sink

Instruction memory that receives the boot-time instruction stream from the instruction injector and then serves instruction fetches to the core. It sits between the injector's write stream (word index plus instruction word) and the fetch stage. It holds fetch off until loading completes, then answers byte-addressed fetch requests with one-cycle latency and error flags.

## Interface
- `DEPTH`, 1024: number of 32-bit instruction words stored.
- `AW`, $clog2(DEPTH): width of the word index.
- `NOP_INSTR`, 32'h0000_0013: word returned on an erroring fetch (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  a load word is presented this cycle.
- `load_addr`  in  32  word index of the load word (not a byte address).
- `load_instr`  in  32  instruction word to store.
- `load_done`  in  1  level; the injector has finished. Sampled only in LOAD.
- `loaded`  out  1  high in RUN.
- `load_count`  out  AW+1  one plus the highest in-range index written; 0 if nothing has been written.
- `load_overflow`  out  1  sticky; a load had `load_addr >= DEPTH`.
- `fetch_req`  in  1  fetch request.
- `fetch_pc`  in  32  byte address of the fetch.
- `fetch_ready`  out  1  combinational: high when in RUN.
- `fetch_valid`  out  1  response valid, one cycle after an accepted request.
- `fetch_instr`  out  32  fetched word.
- `fetch_err`  out  1  qualifies `fetch_valid`; the fetch was illegal.

## Operation
- Two states: LOAD (the reset state) and RUN.
  - LOAD → RUN on the first edge at which `load_done` is high.
  - RUN holds until reset.
- **In LOAD:**
  - An edge with `load_valid` writes `mem[load_addr[AW-1:0]]` if `load_addr < DEPTH`. Otherwise nothing is written and `load_overflow` is set.
  - A repeated index overwrites the earlier word. The last write wins.
  - `load_count` becomes `max(load_count, load_addr+1)` for in-range writes only.
  - If `load_valid` and `load_done` are high on the same edge, the write is performed and the state moves to RUN.
- **In RUN:**
  - `load_valid` is ignored: no write, no change to `load_count` or `load_overflow`.
  - Fetch is accepted when `fetch_req && fetch_ready`. The word index is `fetch_pc[AW+1:2]`.
  - A fetch is an error if any of these hold: `fetch_pc[1:0] != 0`, `fetch_pc >= 4*DEPTH`, or the word index is `>= load_count`.
  - On an error, the response is `fetch_instr = NOP_INSTR` with `fetch_err = 1`.
  - Otherwise the response is `fetch_instr = mem[index]` with `fetch_err = 0`.
- **Fetches during LOAD** are not accepted (`fetch_ready = 0`). No response is produced, and the requester must hold its request.
- **Arithmetic:** comparisons use the full 32-bit `load_addr` and `fetch_pc`. There is no wrap-around or truncation before the range checks.

## Timing
- **Reset values:**
  - state = LOAD
  - `loaded` = 0, `load_count` = 0, `load_overflow` = 0
  - `fetch_valid` = 0, `fetch_err` = 0, `fetch_instr` = 0
- Memory contents are not reset.
- **Load latency:** a word written at edge N is readable by a fetch accepted at edge N+1 or later. RUN is reached no earlier than the edge after the last write, except in the simultaneous write-and-done case above.
- **Fetch latency:** a request accepted at edge N produces `fetch_valid` = 1 in the cycle after edge N, with `fetch_instr` and `fetch_err` registered.
  - The block accepts back-to-back requests at one per cycle.
  - `fetch_valid` is low in any cycle following an edge with no accepted request.
  - `fetch_instr` and `fetch_err` hold their last values when `fetch_valid` is low.
- **Reset mid-operation:** asserting `rst_n` low immediately returns the block to LOAD and clears every output and counter. A response that was in flight is dropped. Stored words remain but are unreachable until reloaded, because `load_count` = 0.

## Structure
- The shared package holds `NOP_INSTR`, the default `DEPTH`, and the state enum {LOAD, RUN}.
- One sub-module, `imem_sdp_ram`: a simple dual-port synchronous RAM with one write port and one registered read port, inferable as BRAM.
- The top level keeps the FSM, `load_count`, `load_overflow`, and the fetch error logic. The error flag is pipelined alongside the RAM read.

## Test plan
- Load words 0..2 = FFFF_FFFF, FFFF_FFF0, FFFF_FF00, then assert `load_done`; fetch pc 0, 4, 8 back-to-back → `fetch_valid` three consecutive cycles with those words, `fetch_err` = 0, `load_count` = 3.
- Fetch pc 0x0C after the above → `fetch_instr` = 0000_0013, `fetch_err` = 1. Fetch pc 0x02 → the same error response.
- `fetch_req` with pc 0 during LOAD → `fetch_ready` = 0 and no `fetch_valid`; after `load_done`, the same request completes one cycle later.
- Load index DEPTH (1024) with value 1234_5678 → `load_overflow` = 1, `load_count` unchanged. Load index 5 twice with A then B → fetch pc 0x14 returns B.
- `load_valid` and `load_done` on the same edge, index 0 = DEAD_BEEF → `loaded` = 1 on the next cycle; fetch pc 0 returns DEAD_BEEF. A later `load_valid` in RUN writing index 0 = 0 → fetch still returns DEAD_BEEF.
- Assert `rst_n` low while a fetch response is pending → `fetch_valid` = 0 immediately, `loaded` = 0, `load_count` = 0; after release, fetch pc 0 is not accepted until reload.
